// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_pkg
// Description : Shared types and constants for the AXI read-channel arbiter:
//               FSM encoding, CLINT window defaults, owner codes and the
//               address-window helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_arbiter_pkg;

    // Transaction phases of the single outstanding read
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
    localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Instruction fetches are always full 32-bit words
    localparam logic [2:0] IFU_ARSIZE = 3'b010;

    // base <= addr < base+size, evaluated in 33 bits so a window touching the
    // top of the address space cannot wrap around
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [32:0] a_ext;
        logic [32:0] lo_ext;
        logic [32:0] hi_ext;
        a_ext  = {1'b0, addr};
        lo_ext = {1'b0, base};
        hi_ext = {1'b0, base} + {1'b0, size};
        return (a_ext >= lo_ext) && (a_ext < hi_ext);
    endfunction

endpackage : axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/axi_rd_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin picker. req[0] is IFU, req[1] is LSU.
//               A lone request is granted directly; a tie goes to the side
//               named by prio. On update, priority passes to the side that
//               was not just served.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant,
    output logic       prio_next
);

    // One-hot grant; only a simultaneous request consults priority
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prio == OWNER_LSU) ? 2'b10 : 2'b01;
        end
    end

    // Completion of a transaction hands first claim to the other side
    always_comb begin
        prio_next = prio;
        if (update) begin
            prio_next = (served == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Round-robin arbiter sharing one outstanding AXI4 read between
//               the IFU (bursts) and the LSU (single beats). Routes the grant
//               to the SoC master port or the CLINT, returns R data to its
//               owner, checks burst beat counts and reports busy/owner.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    // IFU read port
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    input  logic [3:0]  ifu_arlen,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU read port
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // SoC master read port
    output logic        mst_arvalid,
    output logic [31:0] mst_araddr,
    output logic [7:0]  mst_arlen,
    output logic [2:0]  mst_arsize,
    output logic [1:0]  mst_arburst,
    input  logic        mst_arready,
    input  logic        mst_rvalid,
    input  logic [31:0] mst_rdata,
    input  logic [1:0]  mst_rresp,
    input  logic        mst_rlast,
    output logic        mst_rready,
    // CLINT read port
    output logic        clint_arvalid,
    output logic [31:0] clint_araddr,
    input  logic        clint_arready,
    input  logic        clint_rvalid,
    input  logic [31:0] clint_rdata,
    input  logic [1:0]  clint_rresp,
    output logic        clint_rready,
    // Status
    output logic        busy,
    output logic        owner,
    output logic        err_beat
);

    // Registered transaction context
    arb_state_t  r_state;
    logic        r_owner;
    logic        r_clint;
    logic [3:0]  r_len;
    logic [3:0]  r_beat;
    logic        r_prio;
    logic        r_err;

    // Next-state values
    arb_state_t  w_state_next;
    logic        w_owner_next;
    logic        w_clint_next;
    logic [3:0]  w_len_next;
    logic [3:0]  w_beat_next;
    logic        w_err_next;
    logic        w_last_hs;

    // Owner/target views of the channels
    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_prio_next;
    logic        w_own_arvalid;
    logic [31:0] w_own_araddr;
    logic        w_tgt_arready;
    logic        w_src_rvalid;
    logic [31:0] w_src_rdata;
    logic [1:0]  w_src_rresp;
    logic        w_src_rlast;
    logic        w_own_rready;

    assign w_req = {lsu_arvalid, ifu_arvalid};

    rr_pick2 u_pick (
        .req       (w_req),
        .prio      (r_prio),
        .update    (w_last_hs),
        .served    (r_owner),
        .grant     (w_grant),
        .prio_next (w_prio_next)
    );

    // State and transaction context registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= OWNER_IFU;
            r_clint <= 1'b0;
            r_len   <= 4'd0;
            r_beat  <= 4'd0;
            r_prio  <= OWNER_IFU;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_clint <= w_clint_next;
            r_len   <= w_len_next;
            r_beat  <= w_beat_next;
            r_prio  <= w_prio_next;
            r_err   <= w_err_next;
        end
    end

    // Arbitration, AR forwarding, R return path and beat checking
    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_clint_next  = r_clint;
        w_len_next    = r_len;
        w_beat_next   = r_beat;
        w_err_next    = r_err;
        w_last_hs     = 1'b0;

        ifu_arready   = 1'b0;
        ifu_rvalid    = 1'b0;
        ifu_rdata     = 32'd0;
        ifu_rresp     = 2'd0;
        ifu_rlast     = 1'b0;
        lsu_arready   = 1'b0;
        lsu_rvalid    = 1'b0;
        lsu_rdata     = 32'd0;
        lsu_rresp     = 2'd0;
        mst_arvalid   = 1'b0;
        mst_araddr    = 32'd0;
        mst_arlen     = 8'd0;
        mst_arsize    = 3'd0;
        mst_arburst   = 2'd0;
        mst_rready    = 1'b0;
        clint_arvalid = 1'b0;
        clint_araddr  = 32'd0;
        clint_rready  = 1'b0;

        w_own_arvalid = (r_owner == OWNER_LSU) ? lsu_arvalid : ifu_arvalid;
        w_own_araddr  = (r_owner == OWNER_LSU) ? lsu_araddr  : ifu_araddr;
        w_own_rready  = (r_owner == OWNER_LSU) ? lsu_rready  : ifu_rready;
        w_tgt_arready = r_clint ? clint_arready : mst_arready;
        w_src_rvalid  = r_clint ? clint_rvalid  : mst_rvalid;
        w_src_rdata   = r_clint ? clint_rdata   : mst_rdata;
        w_src_rresp   = r_clint ? clint_rresp   : mst_rresp;
        // CLINT reads are single beat, so its only beat is the last
        w_src_rlast   = r_clint ? 1'b1          : mst_rlast;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_owner_next = w_grant[1] ? OWNER_LSU : OWNER_IFU;
                    w_clint_next = w_grant[1] &&
                                   addr_in_window(lsu_araddr, CLINT_BASE, CLINT_SIZE);
                    w_len_next   = w_grant[1] ? 4'd0 : ifu_arlen;
                    w_beat_next  = 4'd0;
                    w_state_next = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (r_clint) begin
                    clint_arvalid = w_own_arvalid;
                    clint_araddr  = w_own_araddr;
                end else begin
                    mst_arvalid   = w_own_arvalid;
                    mst_araddr    = w_own_araddr;
                    mst_arlen     = (r_owner == OWNER_LSU) ? 8'd0 : {4'b0000, ifu_arlen};
                    mst_arsize    = (r_owner == OWNER_LSU) ? lsu_arsize : IFU_ARSIZE;
                    mst_arburst   = (r_owner == OWNER_LSU) ? 2'b00 : ifu_arburst;
                end
                if (r_owner == OWNER_LSU) begin
                    lsu_arready = w_tgt_arready;
                end else begin
                    ifu_arready = w_tgt_arready;
                end
                if (w_own_arvalid && w_tgt_arready) begin
                    w_state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                if (r_owner == OWNER_LSU) begin
                    lsu_rvalid = w_src_rvalid;
                    lsu_rdata  = w_src_rdata;
                    lsu_rresp  = w_src_rresp;
                end else begin
                    ifu_rvalid = w_src_rvalid;
                    ifu_rdata  = w_src_rdata;
                    ifu_rresp  = w_src_rresp;
                    ifu_rlast  = w_src_rlast;
                end
                if (r_clint) begin
                    clint_rready = w_own_rready;
                end else begin
                    mst_rready   = w_own_rready;
                end
                if (w_src_rvalid && w_own_rready) begin
                    w_beat_next = r_beat + 4'd1;
                    // Early rlast or missing rlast on the final beat; the
                    // burst still only ends when rlast actually arrives
                    if (w_src_rlast != (r_beat == r_len)) begin
                        w_err_next = 1'b1;
                    end
                    if (w_src_rlast) begin
                        w_state_next = ST_IDLE;
                        w_last_hs    = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign owner    = busy & r_owner;
    assign err_beat = r_err;

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Self-checking bench for axi_rd_arbiter. Requester queues and
//               SoC/CLINT slave responders drive the DUT; a transaction-level
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_araddr;  logic ifu_arvalid; logic [3:0] ifu_arlen; logic [1:0] ifu_arburst;
    logic        ifu_arready; logic [31:0] ifu_rdata; logic [1:0] ifu_rresp; logic ifu_rlast;
    logic        ifu_rvalid;  logic ifu_rready;
    logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic lsu_arvalid; logic lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid; logic lsu_rready;
    logic        mst_arvalid; logic [31:0] mst_araddr; logic [7:0] mst_arlen; logic [2:0] mst_arsize;
    logic [1:0]  mst_arburst; logic mst_arready; logic mst_rvalid; logic [31:0] mst_rdata;
    logic [1:0]  mst_rresp;   logic mst_rlast; logic mst_rready;
    logic        clint_arvalid; logic [31:0] clint_araddr; logic clint_arready; logic clint_rvalid;
    logic [31:0] clint_rdata; logic [1:0] clint_rresp; logic clint_rready;
    logic        busy, owner, err_beat;

    always #5 clock = ~clock;

    axi_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arlen(ifu_arlen),
        .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .mst_arvalid(mst_arvalid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
        .mst_arsize(mst_arsize), .mst_arburst(mst_arburst), .mst_arready(mst_arready),
        .mst_rvalid(mst_rvalid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp),
        .mst_rlast(mst_rlast), .mst_rready(mst_rready),
        .clint_arvalid(clint_arvalid), .clint_araddr(clint_araddr), .clint_arready(clint_arready),
        .clint_rvalid(clint_rvalid), .clint_rdata(clint_rdata), .clint_rresp(clint_rresp),
        .clint_rready(clint_rready),
        .busy(busy), .owner(owner), .err_beat(err_beat)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit    cyc_ok;
    string cyc_msg;

    typedef struct { logic [31:0] addr; logic [3:0] len; logic [2:0] size; } req_t;
    req_t ifu_q[$];
    req_t lsu_q[$];
    bit   ifu_act = 0, lsu_act = 0;
    int   rr_pct = 100, ar_pct = 100, rv_pct = 100;
    bit   rst_cmd = 1, pending_clear = 0;

    // Slave responder state
    bit soc_busy = 0, clint_busy = 0;
    int soc_len = 0, soc_beat = 0, soc_last_at = 0, force_last_at = -1;
    bit use_knob = 0; logic [31:0] knob_data = 32'd0;

    // Handshakes seen at the last check, applied at the next drive
    bit hs_ifu_ar, hs_lsu_ar, hs_mst_ar, hs_clint_ar, hs_mst_r, hs_clint_r;
    logic [7:0] cap_len;
    int grant_log[$];
    int ifu_beats_seen = 0, lsu_rvalid_seen = 0, mst_ar_cnt = 0, clint_ar_cnt = 0;
    logic [31:0] last_lsu_rdata = 32'd0;

    // Reference model: transaction-level view of the arbiter
    bit m_busy = 0, m_addrph = 0, m_owner = 0, m_clint = 0, m_prio = 0, m_err = 0;
    int m_beats = 0, m_len = 0;

    function automatic bit in_clint(logic [31:0] a);
        return (a >= 32'h0200_0000) && (a < 32'h0201_0000);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fld(string name, logic [63:0] act, logic [63:0] exp);
        if (cyc_ok && act !== exp) begin
            cyc_ok  = 0;
            cyc_msg = $sformatf("%s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req_t r;
        reset = rst_cmd;
        if (pending_clear) begin
            ifu_q.delete(); lsu_q.delete();
            ifu_act = 0; lsu_act = 0; soc_busy = 0; clint_busy = 0;
            mst_rvalid = 0; clint_rvalid = 0; force_last_at = -1;
            {hs_ifu_ar, hs_lsu_ar, hs_mst_ar, hs_clint_ar, hs_mst_r, hs_clint_r} = '0;
            pending_clear = 0;
        end
        if (hs_ifu_ar) ifu_act = 0;
        if (hs_lsu_ar) lsu_act = 0;
        if (hs_mst_ar) begin
            soc_busy = 1; soc_len = int'(cap_len); soc_beat = 0;
            if (force_last_at >= 0) begin
                soc_last_at = force_last_at; force_last_at = -1;
            end else begin
                case ($urandom_range(0, 15))
                    0:       soc_last_at = (soc_len > 0) ? $urandom_range(0, soc_len - 1) : soc_len;
                    1:       soc_last_at = soc_len + 1;
                    default: soc_last_at = soc_len;
                endcase
            end
        end
        if (hs_mst_r) begin
            if (mst_rlast) soc_busy = 0; else soc_beat++;
            mst_rvalid = 0;
        end
        if (hs_clint_ar) clint_busy = 1;
        if (hs_clint_r) begin clint_busy = 0; clint_rvalid = 0; end

        if (!ifu_act && ifu_q.size() > 0) begin
            r = ifu_q.pop_front();
            ifu_araddr = r.addr; ifu_arlen = r.len; ifu_arburst = 2'b01; ifu_act = 1;
        end
        if (!lsu_act && lsu_q.size() > 0) begin
            r = lsu_q.pop_front();
            lsu_araddr = r.addr; lsu_arsize = r.size; lsu_act = 1;
        end
        ifu_arvalid   = ifu_act;
        lsu_arvalid   = lsu_act;
        ifu_rready    = ($urandom_range(0, 99) < rr_pct);
        lsu_rready    = ($urandom_range(0, 99) < rr_pct);
        mst_arready   = ($urandom_range(0, 99) < ar_pct);
        clint_arready = ($urandom_range(0, 99) < ar_pct);
        if (soc_busy && !mst_rvalid && $urandom_range(0, 99) < rv_pct) begin
            mst_rvalid = 1; mst_rdata = $urandom; mst_rresp = 2'($urandom_range(0, 3));
            mst_rlast  = (soc_beat == soc_last_at);
        end
        if (clint_busy && !clint_rvalid && $urandom_range(0, 99) < rv_pct) begin
            clint_rvalid = 1; clint_rdata = use_knob ? knob_data : $urandom;
            clint_rresp  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic model_check();
        bit in_addr = m_busy && m_addrph;
        bit in_data = m_busy && !m_addrph;
        bit own_av  = m_owner ? lsu_arvalid : ifu_arvalid;
        bit tgt_ar  = m_clint ? clint_arready : mst_arready;
        bit own_rr  = m_owner ? lsu_rready : ifu_rready;
        bit sv      = m_clint ? clint_rvalid : mst_rvalid;
        logic [31:0] sd = m_clint ? clint_rdata : mst_rdata;
        logic [1:0]  sr = m_clint ? clint_rresp : mst_rresp;
        bit sl      = m_clint ? 1'b1 : mst_rlast;
        cyc_ok = 1; cyc_msg = "";
        fld("busy", busy, m_busy);
        fld("err_beat", err_beat, m_err);
        if (m_busy) fld("owner", owner, m_owner);
        fld("mst_arvalid", mst_arvalid, in_addr && !m_clint && own_av);
        fld("clint_arvalid", clint_arvalid, in_addr && m_clint && own_av);
        fld("ifu_arready", ifu_arready, in_addr && !m_owner && tgt_ar);
        fld("lsu_arready", lsu_arready, in_addr && m_owner && tgt_ar);
        if (in_addr && !m_clint && own_av) begin
            fld("mst_araddr", mst_araddr, m_owner ? lsu_araddr : ifu_araddr);
            fld("mst_arlen", mst_arlen, m_owner ? 8'd0 : {4'd0, ifu_arlen});
            fld("mst_arsize", mst_arsize, m_owner ? lsu_arsize : 3'b010);
            fld("mst_arburst", mst_arburst, m_owner ? 2'b00 : ifu_arburst);
        end
        if (in_addr && m_clint && own_av) fld("clint_araddr", clint_araddr, lsu_araddr);
        fld("mst_rready", mst_rready, in_data && !m_clint && own_rr);
        fld("clint_rready", clint_rready, in_data && m_clint && own_rr);
        fld("ifu_rvalid", ifu_rvalid, in_data && !m_owner && sv);
        fld("lsu_rvalid", lsu_rvalid, in_data && m_owner && sv);
        if (in_data && !m_owner) begin
            if (sv) begin
                fld("ifu_rdata", ifu_rdata, sd); fld("ifu_rresp", ifu_rresp, sr);
                fld("ifu_rlast", ifu_rlast, sl);
            end
            fld("lsu_rdata_idle", lsu_rdata, 0); fld("lsu_rresp_idle", lsu_rresp, 0);
        end
        if (in_data && m_owner) begin
            if (sv) begin
                fld("lsu_rdata", lsu_rdata, sd); fld("lsu_rresp", lsu_rresp, sr);
            end
            fld("ifu_rdata_idle", ifu_rdata, 0); fld("ifu_rresp_idle", ifu_rresp, 0);
        end
        total++;
        if (!cyc_ok) begin
            bad++;
            $display("FAIL cycle %0d %s", cyc_n, cyc_msg);
        end
    endtask

    task automatic observe();
        hs_ifu_ar   = ifu_arvalid && ifu_arready;
        hs_lsu_ar   = lsu_arvalid && lsu_arready;
        hs_mst_ar   = mst_arvalid && mst_arready;
        hs_clint_ar = clint_arvalid && clint_arready;
        hs_mst_r    = mst_rvalid && mst_rready;
        hs_clint_r  = clint_rvalid && clint_rready;
        cap_len     = mst_arlen;
        if (hs_ifu_ar) grant_log.push_back(0);
        if (hs_lsu_ar) grant_log.push_back(1);
        if (hs_mst_ar) mst_ar_cnt++;
        if (hs_clint_ar) clint_ar_cnt++;
        if (ifu_rvalid && ifu_rready) ifu_beats_seen++;
        if (lsu_rvalid) lsu_rvalid_seen++;
        if (lsu_rvalid && lsu_rready) last_lsu_rdata = lsu_rdata;
    endtask

    task automatic model_step();
        bit sv, own_av, tgt_ar, own_rr, sl, pick;
        if (reset) begin
            m_busy = 0; m_addrph = 0; m_owner = 0; m_clint = 0; m_prio = 0; m_err = 0;
            m_beats = 0; m_len = 0; pending_clear = 1;
            return;
        end
        own_av = m_owner ? lsu_arvalid : ifu_arvalid;
        tgt_ar = m_clint ? clint_arready : mst_arready;
        own_rr = m_owner ? lsu_rready : ifu_rready;
        sv     = m_clint ? clint_rvalid : mst_rvalid;
        sl     = m_clint ? 1'b1 : mst_rlast;
        if (!m_busy) begin
            if (ifu_arvalid || lsu_arvalid) begin
                pick     = (ifu_arvalid && lsu_arvalid) ? m_prio : lsu_arvalid;
                m_owner  = pick;
                m_clint  = pick && in_clint(lsu_araddr);
                m_len    = pick ? 0 : int'(ifu_arlen);
                m_beats  = 0;
                m_busy   = 1;
                m_addrph = 1;
            end
        end else if (m_addrph) begin
            if (own_av && tgt_ar) m_addrph = 0;
        end else if (sv && own_rr) begin
            if (sl != (m_beats == m_len)) m_err = 1;
            m_beats = (m_beats + 1) % 16;
            if (sl) begin
                m_busy = 0;
                m_prio = !m_owner;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        drive();
        #2;
        cyc_n++;
        model_check();
        observe();
        model_step();
    endtask

    task automatic do_reset();
        rst_cmd = 1; cycle(); rst_cmd = 0; cycle();
    endtask

    task automatic wait_idle(string name, int maxc);
        int n = 0;
        while ((ifu_q.size() > 0 || lsu_q.size() > 0 || ifu_act || lsu_act ||
                soc_busy || clint_busy || busy) && n < maxc) begin
            cycle(); n++;
        end
        chk({name, "_timeout"}, (n < maxc), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4] = '{0, 1, 0, 1};
        reset = 1; ifu_araddr = 0; ifu_arvalid = 0; ifu_arlen = 0; ifu_arburst = 0; ifu_rready = 0;
        lsu_araddr = 0; lsu_arsize = 0; lsu_arvalid = 0; lsu_rready = 0;
        mst_arready = 0; mst_rvalid = 0; mst_rdata = 0; mst_rresp = 0; mst_rlast = 0;
        clint_arready = 0; clint_rvalid = 0; clint_rdata = 0; clint_rresp = 0;
        {hs_ifu_ar, hs_lsu_ar, hs_mst_ar, hs_clint_ar, hs_mst_r, hs_clint_r} = '0;
        cap_len = 0;

        repeat (3) cycle();
        chk("reset_busy", busy, 0);
        chk("reset_err_beat", err_beat, 0);
        chk("reset_mst_arvalid", mst_arvalid, 0);
        rst_cmd = 0; cycle();

        // IFU-only burst of 4
        ifu_beats_seen = 0; lsu_rvalid_seen = 0;
        ifu_q.push_back('{32'h8000_0000, 4'd3, 3'd2});
        wait_idle("t1", 200);
        chk("t1_ifu_beats", ifu_beats_seen, 4);
        chk("t1_err_beat", err_beat, 0);
        chk("t1_lsu_quiet", lsu_rvalid_seen, 0);

        // Simultaneous requests alternate IFU, LSU, IFU, LSU
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 2; k++) begin
            ifu_q.push_back('{32'h8000_0100, 4'd1, 3'd2});
            lsu_q.push_back('{32'h8000_1000, 4'd0, 3'd2});
            wait_idle("t2", 200);
        end
        chk("t2_grants", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            chk($sformatf("t2_grant%0d", k), grant_log[k], exp_order[k]);

        // CLINT hit returns its data to the LSU
        use_knob = 1; knob_data = 32'h1234; mst_ar_cnt = 0; clint_ar_cnt = 0;
        lsu_q.push_back('{32'h0200_BFF8, 4'd0, 3'd2});
        wait_idle("t3", 200);
        chk("t3_clint_ar", clint_ar_cnt, 1);
        chk("t3_mst_ar", mst_ar_cnt, 0);
        chk("t3_lsu_rdata", last_lsu_rdata, 32'h1234);
        use_knob = 0;

        // Just outside the window on both sides goes to the SoC
        mst_ar_cnt = 0; clint_ar_cnt = 0;
        lsu_q.push_back('{32'h0201_0000, 4'd0, 3'd2});
        lsu_q.push_back('{32'h01FF_FFFC, 4'd0, 3'd2});
        wait_idle("t4", 200);
        chk("t4_mst_ar", mst_ar_cnt, 2);
        chk("t4_clint_ar", clint_ar_cnt, 0);

        // Early rlast sets the sticky error
        force_last_at = 2;
        ifu_q.push_back('{32'h8000_0200, 4'd3, 3'd2});
        wait_idle("t5", 200);
        chk("t5_err_beat", err_beat, 1);
        chk("t5_idle", busy, 0);
        ifu_beats_seen = 0;
        ifu_q.push_back('{32'h8000_0300, 4'd1, 3'd2});
        wait_idle("t5b", 200);
        chk("t5_next_beats", ifu_beats_seen, 2);
        chk("t5_err_sticky", err_beat, 1);

        // Reset in the middle of a data phase
        begin
            int n = 0;
            ifu_q.push_back('{32'h8000_0400, 4'd7, 3'd2});
            while (!(ifu_rvalid && mst_rvalid) && n < 50) begin cycle(); n++; end
            chk("t6_reached_data", (n < 50), 1);
        end
        rst_cmd = 1; cycle(); rst_cmd = 0; cycle();
        chk("t6_busy", busy, 0);
        chk("t6_mst_rready", mst_rready, 0);
        chk("t6_ifu_rvalid", ifu_rvalid, 0);
        chk("t6_err_cleared", err_beat, 0);
        grant_log.delete();
        ifu_q.push_back('{32'h8000_0500, 4'd0, 3'd2});
        lsu_q.push_back('{32'h8000_0600, 4'd0, 3'd2});
        wait_idle("t6b", 200);
        chk("t6_ifu_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Randomized traffic with back-pressure and beat-count faults
        rr_pct = 70; ar_pct = 60; rv_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            if (ifu_q.size() == 0 && !ifu_act && $urandom_range(0, 7) == 0)
                ifu_q.push_back('{$urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 7)), 3'd2});
            if (lsu_q.size() == 0 && !lsu_act && $urandom_range(0, 7) == 0) begin
                logic [31:0] a;
                case ($urandom_range(0, 5))
                    0: a = 32'h0200_0000 + ($urandom_range(0, 16'hFFFF) & 32'hFFFC);
                    1: a = 32'h0200_0000;
                    2: a = 32'h0200_FFFC;
                    3: a = 32'h0201_0000;
                    4: a = 32'h01FF_FFFC;
                    default: a = $urandom;
                endcase
                lsu_q.push_back('{a, 4'd0, 3'($urandom_range(0, 2))});
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end
        wait_idle("final", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
